// File: rtl/rsa_pkg.sv
// Shared types for the RSA256 datapath: operand width, Montgomery FSM states, accumulator type.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SUB,
        S_DONE
    } mont_state_t;

    typedef logic [RSA_WIDTH+1:0] mont_acc_t;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: m' = (m + a_bit*b + q*N) / 2, with q chosen so the sum is even.
module mont_step
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH+1:0] m_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    input  logic             a_bit_i,
    output logic [WIDTH+1:0] m_o
);

    localparam int unsigned ACC_W = WIDTH + 2;

    logic [ACC_W-1:0] t_add_b;
    logic [ACC_W-1:0] t_add_n;

    // With m < 2N the sum stays below 4N, so WIDTH+2 bits never overflow for legal operands.
    always_comb begin
        t_add_b = m_i + (a_bit_i ? ACC_W'(b_i) : ACC_W'(0));
        t_add_n = t_add_b + (t_add_b[0] ? ACC_W'(n_i) : ACC_W'(0));
        m_o     = t_add_n >> 1;
    end

endmodule

// File: rtl/montgomery_product.sv
// Bit-serial Montgomery multiplier: o_montgomery = a*b*2^-WIDTH mod N, one result per WIDTH+3 cycles.
// Define MONT_BUSY_EN to add the o_busy status output.
module montgomery_product
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_N,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_montgomery,
    output logic             o_ready
`ifdef MONT_BUSY_EN
    ,
    output logic             o_busy
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = WIDTH + 2;

    mont_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [ACC_W-1:0] m_q, m_d;
    logic [ACC_W-1:0] m_step;
    logic             ready_q, ready_d;
`ifdef MONT_BUSY_EN
    logic             busy_q, busy_d;
`endif

    // a is shifted right each iteration so bit i is always at a_q[0].
    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .m_i     (m_q),
        .b_i     (b_q),
        .n_i     (n_q),
        .a_bit_i (a_q[0]),
        .m_o     (m_step)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
`ifdef MONT_BUSY_EN
            busy_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            ready_q <= ready_d;
`ifdef MONT_BUSY_EN
            busy_q  <= busy_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    n_d     = i_N;
                    a_d     = i_a;
                    b_d     = i_b;
                    m_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                m_d   = m_step;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SUB;
                end
            end
            // m < 2N after the loop, so a single conditional subtract fully reduces it.
            S_SUB: begin
                if (m_q >= ACC_W'(n_q)) begin
                    m_d = m_q - ACC_W'(n_q);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                res_d   = m_q[WIDTH-1:0];
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MONT_BUSY_EN
        busy_d = (state_d != S_IDLE);
`endif
    end

    assign o_montgomery = res_q;
    assign o_ready      = ready_q;
`ifdef MONT_BUSY_EN
    assign o_busy       = busy_q;
`endif

endmodule

// File: tb/tb_montgomery_product.sv
// Scoreboard bench for montgomery_product: directed cases, reset abort, random back-to-back ops.
`timescale 1ns/100ps
module tb_montgomery_product;

    localparam int unsigned W       = 256;
    localparam int unsigned LAT     = W + 2;
    localparam int          N_RAND  = 200;

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_N = '0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic [W-1:0] o_montgomery;
    logic         o_ready;
`ifdef MONT_BUSY_EN
    logic         o_busy;
`endif

    exp_t sb[$];
    exp_t e;
    int   edge_n    = 0;
    int   busy_from = 1;
    int   busy_to   = 0;
    int   checks    = 0;
    int   failures  = 0;

    montgomery_product dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_N          (i_N),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_montgomery (o_montgomery),
        .o_ready      (o_ready)
`ifdef MONT_BUSY_EN
        ,
        .o_busy       (o_busy)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edge_n <= edge_n + 1;

    // a*b*2^-W mod n via ordinary modular arithmetic; 2^-W = ((n+1)/2)^(2^log2(W)) mod n.
    function automatic logic [W-1:0] mont_ref(input logic [W-1:0] n, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] nn, aa, bb, prod, rinv, r;
        nn   = {{W{1'b0}}, n};
        aa   = {{W{1'b0}}, a};
        bb   = {{W{1'b0}}, b};
        prod = (aa * bb) % nn;
        rinv = (nn + 1) >> 1;
        for (int k = 0; k < $clog2(W); k++) rinv = (rinv * rinv) % nn;
        r = (prod * rinv) % nn;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: samples 2ns after each rising edge, pops the scoreboard on every o_ready.
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            if (o_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_ready", W'(o_ready), W'(0));
                end else begin
                    e = sb.pop_front();
                    check("result", o_montgomery, e.res);
                    check("latency_edge", W'(edge_n), W'(e.due));
                end
            end else if (sb.size() != 0 && edge_n >= sb[0].due) begin
                check("ready_missing", W'(o_ready), W'(1));
                void'(sb.pop_front());
            end
`ifdef MONT_BUSY_EN
            check("busy", W'(o_busy), W'(edge_n >= busy_from && edge_n <= busy_to));
`endif
        end
    end

    task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp);
        @(negedge i_clk);
        i_N     = n;
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        sb.push_back('{res: exp, due: edge_n + LAT});
        busy_from = edge_n;
        busy_to   = edge_n + LAT - 1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2 * LAT) begin
            @(posedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p25519;
        logic [W-1:0] rn, ra, rb;

        p25519 = (W'(1) << 255) - W'(19);

        repeat (3) @(posedge i_clk);
        #2;
        check("reset_result", o_montgomery, W'(0));
        check("reset_ready", W'(o_ready), W'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Basic product and decode round trip modulo 13.
        start_op(W'(13), W'(5), W'(7), W'(3));
        wait_drain();
        start_op(W'(13), W'(2), W'(1), W'(5));
        wait_drain();

        // Curve25519 prime: zero operand and decode of R mod N.
        start_op(p25519, W'(0), p25519 - W'(1), W'(0));
        wait_drain();
        start_op(p25519, W'(38), W'(1), W'(1));
        wait_drain();
        start_op(p25519, p25519 - W'(1), p25519 - W'(1),
                 mont_ref(p25519, p25519 - W'(1), p25519 - W'(1)));
        wait_drain();

        // Second valid while busy must be ignored.
        start_op(W'(13), W'(5), W'(7), W'(3));
        repeat (9) @(negedge i_clk);
        i_N     = p25519;
        i_a     = W'(38);
        i_b     = W'(1);
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_drain();
        repeat (20) @(negedge i_clk);

        // Reset in the middle of CALC aborts with no result.
        start_op(W'(13), W'(5), W'(7), W'(3));
        repeat (100) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        sb.delete();
        busy_to = 0;
        #1;
        check("abort_result", o_montgomery, W'(0));
        check("abort_ready", W'(o_ready), W'(0));
`ifdef MONT_BUSY_EN
        check("abort_busy", W'(o_busy), W'(0));
`endif
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (LAT + 10) @(negedge i_clk);
        start_op(W'(13), W'(5), W'(7), W'(3));
        wait_drain();

        // Random back-to-back ops; inputs and i_valid are scrambled while busy.
        for (int op = 0; op < N_RAND; op++) begin
            rn = rand256() | W'(1);
            if (rn == W'(1)) rn = W'(3);
            ra = rand256() % rn;
            rb = rand256() % rn;
            start_op(rn, ra, rb, mont_ref(rn, ra, rb));
            for (int j = 0; j < int'(W) + 1; j++) begin
                @(negedge i_clk);
                i_valid = ($urandom_range(0, 15) == 0);
                i_N     = rand256();
                i_a     = rand256();
                i_b     = rand256();
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_drain();
        repeat (10) @(negedge i_clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
